apb_mem_slave: RTL and testbench

Parametrised APB memory slave; next generation of the fixed 8-bit/256-entry slaves on the APB bus. Adds configurable data/address width and depth, programmable wait states, byte write strobes, and PSLVERR on out-of-range access. Sits behind the APB master/decoder as one PSEL target. Its PRDATA/PREADY/PSLVERR feed the master's response mux.

---
 rtl/apb_mem_slave.sv | 117 +++++++++++
 tb/tb_apb_mem_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// Parametrised APB memory slave with programmable wait states, byte strobes
// and PSLVERR on accesses at or beyond DEPTH.
module apb_mem_slave #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                PCLK,
   input  logic                PRSTn,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [ADDR_W-1:0]   PADDR,
   input  logic [DATA_W-1:0]   PWDATA,
   input  logic [DATA_W/8-1:0] PSTRB,
   output logic [DATA_W-1:0]   PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable and never matches.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              setup;
   logic              setup_err;
   logic              write_en;
   logic [IDX_W-1:0]  setup_idx;
   logic [IDX_W-1:0]  commit_idx;

   assign setup      = (state_q == IDLE) && PSEL && !PENABLE;
   assign setup_err  = {1'b0, PADDR} >= DEPTH_L;
   assign setup_idx  = PADDR[IDX_W-1:0];
   assign commit_idx = addr_q[IDX_W-1:0];

   assign PREADY   = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
   assign PSLVERR  = PREADY && err_q;
   assign write_en = PREADY && write_q && !err_q;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (setup) begin
               state_d = ACCESS;
               cnt_d   = WAIT_L;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (PENABLE) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge PCLK or negedge PRSTn) begin
      if (!PRSTn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         PRDATA  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            err_q   <= setup_err;
            if (!PWRITE) begin
               PRDATA <= setup_err ? '0 : mem[setup_idx];
            end
         end
      end
   end

   // NOTE: the storage array has no reset; its contents are undefined until
   // written, which keeps it mappable onto plain RAM.
   always_ff @(posedge PCLK) begin
      if (write_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (PSTRB[b]) begin
               mem[commit_idx][8*b +: 8] <= PWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three configurations on one shared bus,
// checked every cycle against a transaction-level memory model.
module tb_apb_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  psel = 3'b000;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  paddr = 8'h00;
   logic [31:0] pwdata = 32'h0;
   logic [3:0]  pstrb = 4'h0;

   logic [7:0]  prdata_a, prdata_c;
   logic [31:0] prdata_b;
   logic [2:0]  pready, pslverr;
   logic [31:0] rd_v [3];

   int total = 0;
   int bad = 0;

   int   waits  [3] = '{0, 3, 2};
   int   depths [3] = '{200, 256, 256};
   bit   exp_ready [3];
   bit   exp_err   [3];
   bit   exp_read  [3];
   logic [31:0] exp_data [3];
   logic [31:0] mdl [3][256];
   bit   cmp_en = 1'b0;

   always #5 clk = ~clk;

   apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(0)) u_a (
      .PCLK(clk), .PRSTn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]),
      .PRDATA(prdata_a), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(3)) u_b (
      .PCLK(clk), .PRSTn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata_b), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_c (
      .PCLK(clk), .PRSTn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]),
      .PRDATA(prdata_c), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   assign rd_v[0] = {24'h0, prdata_a};
   assign rd_v[1] = prdata_b;
   assign rd_v[2] = {24'h0, prdata_c};

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every slave against the model expectations.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("pready[%0d]", i), 32'(pready[i]), 32'(exp_ready[i]));
            if (exp_ready[i]) begin
               check($sformatf("pslverr[%0d]", i), 32'(pslverr[i]), 32'(exp_err[i]));
               if (exp_read[i])
                  check($sformatf("prdata[%0d]", i), rd_v[i], exp_data[i]);
            end
         end
      end
   end

   task automatic clear_exp();
      for (int i = 0; i < 3; i++) begin
         exp_ready[i] = 1'b0;
         exp_err[i]   = 1'b0;
         exp_read[i]  = 1'b0;
         exp_data[i]  = 32'h0;
      end
   endtask

   task automatic idle(int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         psel = 3'b000;
         penable = 1'b0;
         clear_exp();
      end
   endtask

   // One APB transfer on slave i; abort_at > 0 drops PSEL in that access cycle.
   task automatic xfer(int i, bit wr, int addr, logic [31:0] data, logic [3:0] strb,
                       int abort_at);
      bit err;
      int nb;
      bit last;
      err = (addr >= depths[i]);
      nb  = (i == 1) ? 4 : 1;
      @(posedge clk); #1;
      clear_exp();
      psel    = 3'b000;
      psel[i] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr[7:0];
      pwdata  = $urandom;
      pstrb   = 4'($urandom);
      for (int k = 1; k <= waits[i] + 1; k++) begin
         @(posedge clk); #1;
         if (k == abort_at) begin
            psel    = 3'b000;
            penable = 1'b0;
            clear_exp();
            return;
         end
         last    = (k == waits[i] + 1);
         penable = 1'b1;
         pwdata  = last ? data : $urandom;
         pstrb   = last ? strb : 4'($urandom);
         exp_ready[i] = last;
         exp_err[i]   = err;
         exp_read[i]  = !wr;
         exp_data[i]  = err ? 32'h0 : mdl[i][addr];
      end
      if (wr && !err) begin
         for (int b = 0; b < nb; b++)
            if (strb[b]) mdl[i][addr][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++)
         for (int a = 0; a < 256; a++) mdl[i][a] = 32'h0;
      clear_exp();

      // Reset held over a live write setup on slave A.
      psel = 3'b001; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hEE; pstrb = 4'h1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_pready", 32'(pready), 32'h0);
         check("rst_pslverr", 32'(pslverr), 32'h0);
         check("rst_prdata_a", 32'(prdata_a), 32'h0);
         check("rst_prdata_b", prdata_b, 32'h0);
      end
      @(posedge clk); #1;
      psel = 3'b000;
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Zero-wait back-to-back write then read.
      xfer(0, 1'b1, 8'h10, 32'hA5, 4'h1, 0);
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("a_read_10_lit", 32'(prdata_a), 32'hA5);

      // Out-of-range accesses on the DEPTH=200 slave.
      xfer(0, 1'b1, 199, 32'h5A, 4'h1, 0);
      xfer(0, 1'b1, 250, 32'h77, 4'h1, 0);
      @(negedge clk);
      check("a_wr_250_err_lit", 32'(pslverr[0]), 32'h1);
      xfer(0, 1'b0, 250, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("a_rd_250_data_lit", 32'(prdata_a), 32'h0);
      xfer(0, 1'b0, 199, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("a_rd_199_err_lit", 32'(pslverr[0]), 32'h0);
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, 0);

      // PSEL and PENABLE together straight from IDLE must be ignored.
      @(posedge clk); #1;
      clear_exp();
      psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10;
      pwdata = 32'h3C; pstrb = 4'h1;
      idle(0);
      @(posedge clk); #1;
      idle(1);
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("a_violation_kept_lit", 32'(prdata_a), 32'hA5);

      // Reset during the access phase drops the pending write.
      xfer(0, 1'b1, 8'h20, 32'h11, 4'h1, 0);
      @(posedge clk); #1;
      clear_exp();
      psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20;
      @(posedge clk); #1;
      penable = 1'b1; pwdata = 32'h99; pstrb = 4'h1;
      rst_n = 1'b0;
      @(negedge clk);
      check("a_midrst_prdata", 32'(prdata_a), 32'h0);
      @(posedge clk); #1;
      psel = 3'b000; penable = 1'b0;
      rst_n = 1'b1;
      xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("a_midrst_kept_lit", 32'(prdata_a), 32'h11);

      // 32-bit slave with three wait states and partial strobes.
      xfer(1, 1'b1, 3, 32'h12345678, 4'hF, 0);
      xfer(1, 1'b1, 3, 32'hFFFFFFFF, 4'b0101, 0);
      xfer(1, 1'b0, 3, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("b_strobe_lit", prdata_b, 32'h12FF56FF);
      xfer(1, 1'b1, 255, 32'hCAFEF00D, 4'hF, 0);
      xfer(1, 1'b0, 255, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("b_top_addr_lit", prdata_b, 32'hCAFEF00D);

      // Abort with PSEL dropped after one access cycle, then a normal read.
      xfer(2, 1'b1, 5, 32'h42, 4'h1, 0);
      xfer(2, 1'b1, 5, 32'h99, 4'h1, 2);
      xfer(2, 1'b0, 5, 32'h0, 4'h0, 0);
      @(negedge clk);
      check("c_abort_kept_lit", 32'(prdata_c), 32'h42);

      idle(3);
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
